alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single 2-bit ALU datapath (operands a/b 2 bits, select 2 bits, result 3 bits, clocked) among N_REQ requesters. Each request is accepted with a valid/ready handshake, issued to the ALU, and its result is returned with a per-requester response handshake. The block sits between the requesting control logic and the ALU and is the only driver of the ALU's operand and select inputs. It processes one operation at a time and is not pipelined.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ALU_LAT, 1, clock edges from ALU inputs changing to alu_c_i reflecting them (0 = combinational ALU)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_i  in  N_REQ  request valid, one bit per requester
- req_ready_o  out  N_REQ  request accepted (one-hot or zero)
- req_a_i  in  2*N_REQ  packed operand a; requester k uses bits [2k+1:2k]
- req_b_i  in  2*N_REQ  packed operand b, same packing
- req_sel_i  in  2*N_REQ  packed ALU op select, same packing
- rsp_valid_o  out  N_REQ  result valid for requester k (one-hot or zero)
- rsp_ready_i  in  N_REQ  requester k takes result
- rsp_data_o  out  3  result, shared bus, meaningful only while any rsp_valid_o bit is high
- alu_a_o, alu_b_o, alu_sel_o  out  2 each  to ALU a_i, b_i, i_sel
- alu_c_i  in  3  from ALU c_o
- busy_o  out  1  high whenever state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If any req_valid_i bit is set, the arbiter picks grant g.
  - req_ready_o[g] = 1 combinationally in the same cycle, and the handshake completes in that cycle.
  - req_a/b/sel of g are registered into alu_*_o. g is latched. The block moves to EXEC.
- EXEC
  - A down-counter loads ALU_LAT and the block stays in EXEC for ALU_LAT+1 cycles.
  - alu_c_i is captured into rsp_data_o on the last EXEC cycle. The block then moves to RESP.
- RESP
  - rsp_valid_o[g] = 1 until rsp_ready_i[g] = 1. That cycle completes the response and the block returns to IDLE.
  - rsp_ready_i bits of other requesters are ignored.
- req_ready_o is all-zero outside IDLE. Requests arriving during EXEC or RESP wait.
- Requester rule: once req_valid_i[k] rises, it holds until accepted, with stable payload. The block does not check this.
- alu_*_o and rsp_data_o hold their last values between operations and do not return to zero.
- All four select codes pass through unmodified. Result width is 3 bits with no truncation or extension.
- Reset (any time, including mid-EXEC or mid-RESP):
  - state = IDLE, any in-flight result is discarded.
  - req_ready_o = 0, rsp_valid_o = 0, rsp_data_o = 0, alu_a_o/alu_b_o/alu_sel_o = 0, busy_o = 0.
  - RR pointer = 0.

## Timing
- Accept in cycle 0, alu_*_o valid from cycle 1. With the default ALU_LAT=1, rsp_valid_o first rises in cycle 3.
- Generally, rsp_valid_o rises in cycle ALU_LAT+2.
- Minimum spacing between accepts is ALU_LAT+3 cycles, reached when rsp_ready_i is already high in the first RESP cycle.
- Back-to-back: a request held valid during RESP is accepted in the first IDLE cycle after the response completes.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration. The search starts at pointer p and wraps past N_REQ-1 to 0.
  - On each accept, p becomes (g+1) mod N_REQ.
- ALU_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority, lowest index wins.
  - The pointer register is not built.

## Structure
- Package alu_arb_pkg holds:
  - state enum typedef (IDLE, EXEC, RESP)
  - localparams W_OP=2 and W_RES=3
  - latency counter width function/constant derived from ALU_LAT
- Sub-module alu_arb_grant:
  - Inputs: request vector and pointer. Output: one-hot grant.
  - Contains the round-robin and fixed-priority logic under the macro.
  - Top level holds the FSM, operand registers, counter and result register.

## Test plan
- Bench ALU model: registered, 1-cycle latency, sel=00 → a+b. Default parameters unless stated.
- Single request, requester 2: a=3, b=2, sel=00, rsp_ready_i held high → req_ready_o=4'b0100 in cycle 0; rsp_valid_o=4'b0100 in cycle 3 only; rsp_data_o=3'b101.
- All four valid simultaneously for four operations, macro defined → grants in order 0,1,2,3. Macro undefined with all held valid → requester 0 is granted every time.
- Response backpressure: rsp_ready_i low for 5 cycles → rsp_valid_o and rsp_data_o stay stable, req_ready_o stays 0 throughout, busy_o=1.
- Requester 1 asserts valid during EXEC of requester 0 → no req_ready_o[1] until the cycle after requester 0's response completes.
- rst_n pulsed low during EXEC → on release all outputs are 0, no rsp_valid_o for the lost operation, and the next request is accepted from IDLE normally.
- ALU_LAT=0 with a combinational model, a=1, b=1, sel=00 → rsp_valid_o in cycle 2 with rsp_data_o=3'b010.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and widths for the ALU arbiter slice.
// Counter width is derived from the ALU latency so ALU_LAT=0/1 still gets a 1-bit counter.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int W_OP  = 2;
  localparam int W_RES = 3;

  function automatic int lat_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// One-hot grant picker, combinational. Round-robin from ptr when ALU_ARB_ROUND_ROBIN_EN
// is defined, otherwise fixed priority with the lowest index winning (ptr ignored).
module alu_arb_grant
  import alu_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Walk the ring starting at ptr, wrapping past N_REQ-1 back to 0.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (PW+1)'(i);
      if (sum >= (PW+1)'(N_REQ)) sum = sum - (PW+1)'(N_REQ);
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic found;
  logic unused_ptr;

  assign unused_ptr = ^ptr;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU among N_REQ requesters, one op at a time; rsp_valid rises ALU_LAT+2 cycles
// after accept and holds until rsp_ready; req_ready is low outside IDLE. ALU_ARB_ROUND_ROBIN_EN selects RR.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid_i,
  output logic [N_REQ-1:0]        req_ready_o,
  input  logic [W_OP*N_REQ-1:0]   req_a_i,
  input  logic [W_OP*N_REQ-1:0]   req_b_i,
  input  logic [W_OP*N_REQ-1:0]   req_sel_i,
  output logic [N_REQ-1:0]        rsp_valid_o,
  input  logic [N_REQ-1:0]        rsp_ready_i,
  output logic [W_RES-1:0]        rsp_data_o,
  output logic [W_OP-1:0]         alu_a_o,
  output logic [W_OP-1:0]         alu_b_o,
  output logic [W_OP-1:0]         alu_sel_o,
  input  logic [W_RES-1:0]        alu_c_i,
  output logic                    busy_o
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = lat_cnt_w(ALU_LAT);

  state_t           state, state_nxt;
  logic [N_REQ-1:0] gnt, gnt_q;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    ptr;
  logic [W_OP-1:0]  a_mux, b_mux, sel_mux;
  logic             accept, exec_done, rsp_done;

  assign accept    = (state == IDLE) && (|req_valid_i);
  assign exec_done = (state == EXEC) && (cnt == '0);
  assign rsp_done  = (state == RESP) && (|(rsp_ready_i & gnt_q));

  alu_arb_grant #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_grant (
    .req (req_valid_i),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    a_mux   = '0;
    b_mux   = '0;
    sel_mux = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        a_mux   = req_a_i[W_OP*k +: W_OP];
        b_mux   = req_b_i[W_OP*k +: W_OP];
        sel_mux = req_sel_i[W_OP*k +: W_OP];
      end
    end
  end

`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] gidx;

  always_comb begin
    gidx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) gidx = PW'(k);
    end
  end

  // Next search starts just past the requester we served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (accept) ptr <= (gidx == PW'(N_REQ-1)) ? '0 : gidx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = EXEC;
      EXEC:    if (exec_done) state_nxt = RESP;
      RESP:    if (rsp_done)  state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == IDLE) ? gnt : '0;
    rsp_valid_o = (state == RESP) ? gnt_q : '0;
    busy_o      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_o    <= '0;
      alu_b_o    <= '0;
      alu_sel_o  <= '0;
      gnt_q      <= '0;
      cnt        <= '0;
      rsp_data_o <= '0;
    end else begin
      if (accept) begin
        alu_a_o   <= a_mux;
        alu_b_o   <= b_mux;
        alu_sel_o <= sel_mux;
        gnt_q     <= gnt;
        cnt       <= CW'(ALU_LAT);
      end else if ((state == EXEC) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (exec_done) rsp_data_o <= alu_c_i;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a registered ALU model on the default instance and a
// combinational model on an ALU_LAT=0 instance; grant order follows ALU_ARB_ROUND_ROBIN_EN.
module tb_alu_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2*N-1:0] req_a, req_b, req_sel;
  logic [2:0]   rsp_data, alu_c;
  logic [1:0]   alu_a, alu_b, alu_sel;
  logic         busy;

  logic [N-1:0] z_req_valid, z_req_ready, z_rsp_valid, z_rsp_ready;
  logic [2*N-1:0] z_req_a, z_req_b, z_req_sel;
  logic [2:0]   z_rsp_data, z_alu_c;
  logic [1:0]   z_alu_a, z_alu_b, z_alu_sel;
  logic         z_busy;

  function automatic logic [2:0] alu_fn(input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
    case (s)
      2'd0:    return {1'b0, a} + {1'b0, b};
      2'd1:    return {1'b0, a & b};
      2'd2:    return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  always @(posedge clk) alu_c <= alu_fn(alu_a, alu_b, alu_sel);
  assign z_alu_c = alu_fn(z_alu_a, z_alu_b, z_alu_sel);

  alu_arbiter #(.N_REQ(N), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel),
    .alu_c_i(alu_c), .busy_o(busy)
  );

  alu_arbiter #(.N_REQ(N), .ALU_LAT(0)) u_dut_lat0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(z_req_valid), .req_ready_o(z_req_ready),
    .req_a_i(z_req_a), .req_b_i(z_req_b), .req_sel_i(z_req_sel),
    .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready), .rsp_data_o(z_rsp_data),
    .alu_a_o(z_alu_a), .alu_b_o(z_alu_b), .alu_sel_o(z_alu_sel),
    .alu_c_i(z_alu_c), .busy_o(z_busy)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] idx;
    logic [2:0] dat;
  } exp_t;

  exp_t rsp_q[$];
  int   acc_q[$];

  int   cyc = 0;
  int   acc_cyc = 0, rise_cyc = 0, done_cyc = 0;
  int   n_acc = 0, n_rsp = 0, vld_cycles = 0;
  logic prev_vld = 1'b0;
  exp_t mon_e;
  int   mon_g;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every accept and every response handshake against the queues.
  always @(negedge clk) begin
    if (req_ready != '0) begin
      n_acc++;
      acc_cyc = cyc;
      if (acc_q.size() == 0) chk("acc_unexpected", 32'(req_ready), 32'd0);
      else begin
        mon_g = acc_q.pop_front();
        chk("acc_grant", 32'(req_ready), 32'd1 << mon_g);
      end
    end
    if (rsp_valid != '0) begin
      vld_cycles++;
      if (!prev_vld) rise_cyc = cyc;
    end
    if ((rsp_valid & rsp_ready) != '0) begin
      n_rsp++;
      done_cyc = cyc;
      if (rsp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        mon_e = rsp_q.pop_front();
        chk("rsp_owner", 32'(rsp_valid), 32'd1 << mon_e.idx);
        chk("rsp_data", 32'(rsp_data), 32'(mon_e.dat));
      end
    end
    prev_vld = |rsp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [1:0] a, input logic [1:0] b, input logic [1:0] s);
    req_a[2*k +: 2]   = a;
    req_b[2*k +: 2]   = b;
    req_sel[2*k +: 2] = s;
  endtask

  task automatic expect_op(input int g, input logic [1:0] a, input logic [1:0] b, input logic [1:0] s,
                           input bit with_rsp);
    exp_t e;
    acc_q.push_back(g);
    e.idx = 2'(g);
    e.dat = alu_fn(a, b, s);
    if (with_rsp) rsp_q.push_back(e);
  endtask

  task automatic wait_rsp(input string tag, input int target);
    int b = 0;
    while (n_rsp < target && b < 200) begin
      tick();
      b++;
    end
    chk(tag, 32'(n_rsp), 32'(target));
  endtask

  task automatic wait_acc(input string tag, input int target);
    int b = 0;
    while (n_acc < target && b < 200) begin
      tick();
      b++;
    end
    chk(tag, 32'(n_acc), 32'(target));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_alu_a"},     32'(alu_a),     32'd0);
    chk({tag, "_alu_b"},     32'(alu_b),     32'd0);
    chk({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_acc, b, za, zr;
    logic [N-1:0] rr;

    rst_n = 1'b0;
    req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = '0;
    z_req_valid = '0; z_req_a = '0; z_req_b = '0; z_req_sel = '0; z_rsp_ready = '0;
    repeat (3) tick();
    @(negedge clk);
    chk_idle_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Single request from requester 2: 3+2.
    rsp_ready  = 4'hF;
    vld_cycles = 0;
    base = n_rsp;
    expect_op(2, 2'd3, 2'd2, 2'd0, 1'b1);
    set_req(2, 2'd3, 2'd2, 2'd0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    wait_rsp("t1_rsp_done", base + 1);
    repeat (2) tick();
    chk("t1_latency", 32'(rise_cyc - acc_cyc), 32'd3);
    chk("t1_vld_cycles", 32'(vld_cycles), 32'd1);
    chk("t1_alu_a_hold", 32'(alu_a), 32'd3);
    chk("t1_alu_b_hold", 32'(alu_b), 32'd2);
    chk("t1_rsp_data_hold", 32'(rsp_data), 32'b101);
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // All four valid; reset first so the pointer starts at 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < N; k++) set_req(k, 2'(k), 2'd3, 2'(k));
    for (int i = 0; i < N; i++) begin
      int g;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      g = i;
`else
      g = 0;
`endif
      expect_op(g, 2'(g), 2'd3, 2'(g), 1'b1);
    end
    base = n_rsp;
    base_acc = n_acc;
    req_valid = 4'hF;
    b = 0;
    while (n_acc < base_acc + 4 && b < 200) begin
      @(negedge clk);
      rr = req_ready;
      tick();
      b++;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      req_valid = req_valid & ~rr;
`endif
    end
    req_valid = '0;
    chk("t2_accepts", 32'(n_acc - base_acc), 32'd4);
    wait_rsp("t2_rsp_done", base + 4);

    // Backpressure on requester 0 while requester 1 waits; other ready bits must be ignored.
    rsp_ready = 4'b1110;
    set_req(0, 2'd2, 2'd3, 2'd2);
    set_req(1, 2'd1, 2'd2, 2'd0);
    expect_op(0, 2'd2, 2'd3, 2'd2, 1'b1);
    expect_op(1, 2'd1, 2'd2, 2'd0, 1'b1);
    base = n_rsp;
    base_acc = n_acc;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t3_req_ready0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0010;
    b = 0;
    while (rsp_valid == '0 && b < 20) begin
      tick();
      b++;
    end
    chk("t3_rsp_seen", 32'(rsp_valid), 32'b0001);
    repeat (5) begin
      @(negedge clk);
      chk("t3_vld_stable", 32'(rsp_valid), 32'b0001);
      chk("t3_dat_stable", 32'(rsp_data), 32'd3);
      chk("t3_no_accept", 32'(req_ready), 32'd0);
      chk("t3_busy", 32'(busy), 32'd1);
      tick();
    end
    rsp_ready = 4'hF;
    wait_rsp("t3_rsp0_done", base + 1);
    wait_acc("t3_acc1", base_acc + 2);
    req_valid = '0;
    chk("t3_b2b_accept", 32'(acc_cyc - done_cyc), 32'd1);
    wait_rsp("t3_rsp1_done", base + 2);

    // Reset in the middle of EXEC: operation is lost.
    set_req(2, 2'd3, 2'd1, 2'd1);
    expect_op(2, 2'd3, 2'd1, 2'd1, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_req_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t5_in_reset");
    tick();
    rst_n = 1'b1;
    vld_cycles = 0;
    @(negedge clk);
    chk_idle_outputs("t5_released");
    repeat (6) tick();
    chk("t5_no_lost_rsp", 32'(vld_cycles), 32'd0);
    base = n_rsp;
    set_req(3, 2'd1, 2'd2, 2'd0);
    expect_op(3, 2'd1, 2'd2, 2'd0, 1'b1);
    req_valid = 4'b1000;
    @(negedge clk);
    chk("t5_new_ready", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    wait_rsp("t5_new_rsp", base + 1);
    chk("t5_new_latency", 32'(rise_cyc - acc_cyc), 32'd3);

    // Combinational ALU instance: 1+1 returns two cycles after accept.
    z_rsp_ready = 4'hF;
    z_req_a[1:0] = 2'd1;
    z_req_b[1:0] = 2'd1;
    z_req_sel[1:0] = 2'd0;
    z_req_valid = 4'b0001;
    @(negedge clk);
    chk("z_req_ready", 32'(z_req_ready), 32'b0001);
    za = cyc;
    tick();
    z_req_valid = '0;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (z_rsp_valid == '0 && b < 20);
    zr = cyc;
    chk("z_rsp_valid", 32'(z_rsp_valid), 32'b0001);
    chk("z_latency", 32'(zr - za), 32'd2);
    chk("z_rsp_data", 32'(z_rsp_data), 32'b010);
    tick();
    chk("z_busy_idle", 32'(z_busy), 32'd0);

    chk("sb_rsp_empty", 32'(rsp_q.size()), 32'd0);
    chk("sb_acc_empty", 32'(acc_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
